// File: rtl/wm8731_cfg_ctrl.sv
// WM8731 configuration master: writes a fixed register table over I2C, retries
// NACKed frames up to MAX_RETRY times, then raises done/codec enable.
module wm8731_cfg_ctrl #(
    parameter int CLK_DIV   = 30,
    parameter int NUM_REG   = 10,
    parameter int MAX_RETRY = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       i2c_sda_i,
    output logic       i2c_scl_o,
    output logic       i2c_sda_oe_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [3:0] reg_idx_o,
    output logic       codec_en_o
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_DONE, S_ERROR
    } state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_tick_cnt;
    logic [1:0]      r_phase;
    logic [2:0]      r_bit;
    logic [1:0]      r_byte;
    logic [3:0]      r_idx;
    logic [RW-1:0]   r_retry;
    logic            r_nack, r_abort, r_fin;
    logic            w_busy, w_tick, w_last_ph, w_go, w_cur_bit;
    logic            w_scl, w_oe;
    logic [15:0]     w_entry;
    logic [7:0]      w_byte;

    // Entries are {addr[6:0], data[8:0]}; the activate entry sits at index 10
    // and is only reached when NUM_REG is raised above the default.
    function automatic logic [15:0] f_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    f_entry = {7'h0F, 9'h000};
            4'd1:    f_entry = {7'h00, 9'h017};
            4'd2:    f_entry = {7'h01, 9'h017};
            4'd3:    f_entry = {7'h02, 9'h079};
            4'd4:    f_entry = {7'h03, 9'h079};
            4'd5:    f_entry = {7'h04, 9'h012};
            4'd6:    f_entry = {7'h05, 9'h000};
            4'd7:    f_entry = {7'h06, 9'h000};
            4'd8:    f_entry = {7'h07, 9'h008};
            4'd9:    f_entry = {7'h08, 9'h000};
            4'd10:   f_entry = {7'h09, 9'h001};
            default: f_entry = 16'h0000;
        endcase
    endfunction

    assign w_entry   = f_entry(r_idx);
    assign w_busy    = (r_state == S_START) || (r_state == S_BIT) || (r_state == S_ACK) ||
                       (r_state == S_STOP)  || (r_state == S_GAP);
    assign w_tick    = w_busy && (r_tick_cnt == CW'(CLK_DIV - 1));
    assign w_last_ph = w_tick && (r_phase == 2'd3);
    assign w_go      = start_i && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));

    always_comb begin
        case (r_byte)
            2'd0:    w_byte = 8'h34;
            2'd1:    w_byte = w_entry[15:8];
            default: w_byte = w_entry[7:0];
        endcase
    end
    assign w_cur_bit = w_byte[3'd7 - r_bit];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_scl  = 1'b1;
        w_oe   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) w_next = S_START;
            end
            S_START: begin
                w_scl = (r_phase != 2'd3);
                w_oe  = (r_phase >= 2'd2);
                if (w_last_ph) w_next = S_BIT;
            end
            S_BIT: begin
                w_scl = (r_phase == 2'd1) || (r_phase == 2'd2);
                w_oe  = ~w_cur_bit;
                if (w_last_ph) w_next = (r_bit == 3'd7) ? S_ACK : S_BIT;
            end
            S_ACK: begin
                w_scl = (r_phase == 2'd1) || (r_phase == 2'd2);
                if (w_last_ph) w_next = (r_nack || (r_byte == 2'd2)) ? S_STOP : S_BIT;
            end
            S_STOP: begin
                w_scl = (r_phase != 2'd0);
                w_oe  = (r_phase <= 2'd1);
                if (w_last_ph) w_next = r_abort ? S_ERROR : S_GAP;
            end
            S_GAP: begin
                if (w_last_ph) w_next = r_fin ? S_DONE : S_START;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // r_nack is sampled at the end of ACK tick 2 and acted on at the end of tick 3.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tick_cnt <= '0;
            r_phase    <= 2'd0;
            r_bit      <= 3'd0;
            r_byte     <= 2'd0;
            r_idx      <= 4'd0;
            r_retry    <= '0;
            r_nack     <= 1'b0;
            r_abort    <= 1'b0;
            r_fin      <= 1'b0;
        end else begin
            r_tick_cnt <= (!w_busy || w_tick) ? '0 : r_tick_cnt + 1'b1;
            if (w_tick) r_phase <= r_phase + 2'd1;
            if (w_go) begin
                r_phase <= 2'd0;
                r_idx   <= 4'd0;
                r_retry <= '0;
                r_nack  <= 1'b0;
                r_abort <= 1'b0;
                r_fin   <= 1'b0;
            end
            if (r_state == S_START) begin
                r_bit  <= 3'd0;
                r_byte <= 2'd0;
            end
            if ((r_state == S_BIT) && w_last_ph) r_bit <= r_bit + 3'd1;
            if ((r_state == S_ACK) && w_tick && (r_phase == 2'd2)) r_nack <= i2c_sda_i;
            if ((r_state == S_ACK) && w_last_ph) begin
                r_byte <= r_byte + 2'd1;
                if (r_nack) begin
                    if (r_retry == RW'(MAX_RETRY)) r_abort <= 1'b1;
                    else                           r_retry <= r_retry + 1'b1;
                end else if (r_byte == 2'd2) begin
                    r_retry <= '0;
                    if (r_idx == 4'(NUM_REG - 1)) r_fin <= 1'b1;
                    else                          r_idx <= r_idx + 4'd1;
                end
            end
        end
    end

    assign i2c_scl_o    = w_scl;
    assign i2c_sda_oe_o = w_oe;
    assign busy_o       = w_busy;
    assign done_o       = (r_state == S_DONE);
    assign err_o        = (r_state == S_ERROR);
    assign codec_en_o   = (r_state == S_DONE);
    assign reg_idx_o    = r_idx;

endmodule
